axis_frame_len_8: RTL and testbench
===================================

// Module: axis_frame_len_8
// PURPOSE
//  Consumes the 8-bit AXI-Stream output of the 64->8 axis_adapter and forwards it unchanged through a registered skid stage.
//  While forwarding, it counts bytes per frame and reports one status word per frame on a valid/ready status port.
//  It is the downstream consumer stage used to check tlast placement and frame length after width conversion.
// PARAMETERS
//  DATA_WIDTH  8     stream data width; fixed at 8, one byte per beat, tkeep is 1 bit
//  LEN_WIDTH   16    width of the frame byte counter and of status_frame_len
//  MAX_LEN     1518  oversize threshold in bytes; used only with AXIS_FRAME_LEN_MAXCHK_EN
// PORTS
//  clk                 in   1          clock; all logic is on the rising edge
//  rst                 in   1          asynchronous, active-high reset
//  input_axis_tdata    in   8          input byte (from axis_adapter)
//  input_axis_tkeep    in   1          byte valid; a beat with tkeep=0 is forwarded but not counted
//  input_axis_tvalid   in   1          input valid
//  input_axis_tready   out  1          input ready; registered
//  input_axis_tlast    in   1          end of frame
//  input_axis_tuser    in   1          frame error flag; sampled on the tlast beat
//  output_axis_tdata   out  8          forwarded byte
//  output_axis_tkeep   out  1          forwarded keep
//  output_axis_tvalid  out  1          output valid
//  output_axis_tready  in   1          output ready
//  output_axis_tlast   out  1          forwarded tlast
//  output_axis_tuser   out  1          forwarded tuser
//  status_valid        out  1          status word available
//  status_ready        in   1          status consumer ready
//  status_frame_len    out  LEN_WIDTH  number of bytes with tkeep=1 in the frame; saturates at all-ones
//  status_error        out  1          tuser of the frame's tlast beat
//  status_oversize     out  1          frame length > MAX_LEN; tied 0 when AXIS_FRAME_LEN_MAXCHK_EN is not defined
//  status_dropped      out  1          sticky: at least one status word was lost; cleared only by rst
// BEHAVIOUR
//  Reset values: all outputs 0, except input_axis_tready=1. Byte counter = 0. Skid buffer empty.
//  Data path: two-entry skid buffer (main and temp registers); one cycle latency from input to output; no bubbles at full rate.
//   - Input handshake: a beat is accepted when input_axis_tvalid && input_axis_tready.
//   - input_axis_tready is registered: it is 1 next cycle iff the temp register is empty, or will be empty next cycle.
//   - Output is held stable while output_axis_tvalid && !output_axis_tready (AXIS rule); no beat is lost or duplicated.
//   - tdata, tkeep, tlast and tuser travel together, bit-exact.
//  Counting happens on input acceptance:
//   - count <= count + tkeep, saturating at 2^LEN_WIDTH-1.
//   - On an accepted tlast beat: len = count + tkeep (saturating); count <= 0 in the same cycle.
//  Status register (single entry):
//   - Loaded on an accepted tlast beat; status_valid=1 the cycle after that beat is accepted.
//   - Cleared on status_valid && status_ready.
//   - Pop and new load in the same cycle: the new word is loaded and status_valid stays 1.
//   - Full (status_valid && !status_ready) when a new frame ends: the new word is discarded, the held word is kept, status_dropped <= 1.
//   - The status port never back-pressures the data path.
//  Zero-byte frame (tlast with tkeep=0 and count=0): status reports len=0.
//  Reset mid-frame: counter, skid buffer and status clear immediately; the partial frame is lost and no status is issued for it.
// CONFIGURATION
//  AXIS_FRAME_LEN_MAXCHK_EN defined:
//   - status_oversize = (len > MAX_LEN), registered with the status word.
//   - output_axis_tuser is forced to 1 on the tlast beat of an oversize frame.
//  AXIS_FRAME_LEN_MAXCHK_EN undefined: status_oversize is constant 0, tuser passes through unmodified, and the comparator is not built.
// STRUCTURE
//  Shared package axis_pkg:
//   - localparam AXIS_BYTE_W = 8.
//   - Default LEN_WIDTH.
//   - Status word field order {oversize, error, frame_len}, used by later status FIFOs.
//  One sub-module: axis_skid_reg (parameterised-width two-entry skid buffer carrying {tdata, tkeep, tlast, tuser}).
//  Counter and status logic stay in the top module.
// TESTING
//  1. 5-byte frame cd ab cd ab cd, tkeep=1, tlast on 5th, output_axis_tready=1:
//     -> output is identical, delayed 1 cycle, with tlast on the last cd.
//     -> status_valid, len=5, error=0.
//  2. Same frame, output_axis_tready=0 for 3 cycles mid-frame:
//     -> input_axis_tready drops within 2 beats; output is the full 5 bytes in order; len=5.
//  3. 1-byte frame with tuser=1, then a 0-byte frame (tlast, tkeep=0), popping status between them:
//     -> first status: len=1, error=1; second status: len=0.
//  4. Hold status_ready=0 across two 3-byte frames:
//     -> first status stays len=3; status_dropped=1 after the 2nd tlast.
//     -> after a pop, status_valid=0.
//  5. Assert rst after 2 bytes of a frame, then send a 4-byte frame:
//     -> all outputs return to reset values; next status len=4; status_dropped=0.
//  6. AXIS_FRAME_LEN_MAXCHK_EN defined, MAX_LEN=4, 5-byte frame:
//     -> status_oversize=1 and output_axis_tuser=1 on the tlast beat.
//     -> with the macro undefined, both are 0.

Source files
------------

// File: rtl/axis_pkg.sv
// ============================================================================
// Module   : axis_pkg
// Brief    : Shared AXI-Stream constants and the frame status word layout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkg;

  localparam int AXIS_BYTE_W = 8;
  localparam int AXIS_LEN_W  = 16;

  // Status word layout {oversize, error, frame_len}; downstream status FIFOs store it as is.
  typedef struct packed {
    logic                  oversize;
    logic                  error;
    logic [AXIS_LEN_W-1:0] frame_len;
  } axis_status_t;

  localparam int AXIS_STATUS_W = AXIS_LEN_W + 2;

endpackage

`default_nettype wire

// File: rtl/axis_skid_reg.sv
// ============================================================================
// Module   : axis_skid_reg
// Brief    : Two-entry (main + temp) registered skid buffer, one cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  logic [WIDTH-1:0] r_main_data;
  logic             r_main_valid;
  logic [WIDTH-1:0] r_temp_data;
  logic             r_temp_valid;
  logic             r_ready;
  logic             w_ready_early;

  // Ready next cycle if the temp slot is free now and cannot fill this cycle.
  assign w_ready_early = i_out_ready || (!r_temp_valid && (!r_main_valid || !i_in_valid));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready      <= 1'b1;
      r_main_data  <= '0;
      r_main_valid <= 1'b0;
      r_temp_data  <= '0;
      r_temp_valid <= 1'b0;
    end else begin
      r_ready <= w_ready_early;
      if (r_ready) begin
        if (i_out_ready || !r_main_valid) begin
          r_main_data  <= i_in_data;
          r_main_valid <= i_in_valid;
        end else begin
          r_temp_data  <= i_in_data;
          r_temp_valid <= i_in_valid;
        end
      end else if (i_out_ready) begin
        r_main_data  <= r_temp_data;
        r_main_valid <= r_temp_valid;
        r_temp_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready  = r_ready;
  assign o_out_data  = r_main_data;
  assign o_out_valid = r_main_valid;

endmodule

`default_nettype wire

// File: rtl/axis_frame_len_8.sv
// ============================================================================
// Module   : axis_frame_len_8
// Brief    : 8-bit AXIS pass-through with per-frame byte count status port.
//            Optional oversize check enabled by AXIS_FRAME_LEN_MAXCHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_frame_len_8
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_BYTE_W,
  parameter int LEN_WIDTH  = AXIS_LEN_W,
  parameter int MAX_LEN    = 1518
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tkeep,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tkeep,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  output logic                  status_valid,
  input  logic                  status_ready,
  output logic [LEN_WIDTH-1:0]  status_frame_len,
  output logic                  status_error,
  output logic                  status_oversize,
  output logic                  status_dropped
);

  localparam int                   c_SKID_W  = DATA_WIDTH + 3;
  localparam int                   c_STAT_W  = LEN_WIDTH + 2;
  localparam logic [LEN_WIDTH-1:0] c_LEN_SAT = '1;

  logic                 w_in_acc;
  logic [LEN_WIDTH-1:0] w_len;
  logic                 w_oversize;
  logic                 w_tuser_in;
  logic [c_SKID_W-1:0]  w_skid_in;
  logic [c_SKID_W-1:0]  w_skid_out;

  logic [LEN_WIDTH-1:0] r_count;
  logic                 r_status_valid;
  logic [c_STAT_W-1:0]  r_status_word;
  logic                 r_status_dropped;

  if (MAX_LEN < 0) begin : g_max_len_negative
  end

  assign w_in_acc = input_axis_tvalid && input_axis_tready;
  assign w_len    = (r_count == c_LEN_SAT) ? r_count : r_count + LEN_WIDTH'(input_axis_tkeep);

`ifdef AXIS_FRAME_LEN_MAXCHK_EN
  assign w_oversize = (32'(w_len) > MAX_LEN);
  // Flag the tlast beat of an oversize frame on the forwarded stream too.
  assign w_tuser_in = input_axis_tuser || (input_axis_tlast && w_oversize);
`else
  assign w_oversize = 1'b0;
  assign w_tuser_in = input_axis_tuser;
`endif

  assign w_skid_in = {input_axis_tdata, input_axis_tkeep, input_axis_tlast, w_tuser_in};

  axis_skid_reg #(
    .WIDTH (c_SKID_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_in_data   (w_skid_in),
    .i_in_valid  (input_axis_tvalid),
    .o_in_ready  (input_axis_tready),
    .o_out_data  (w_skid_out),
    .o_out_valid (output_axis_tvalid),
    .i_out_ready (output_axis_tready)
  );

  assign {output_axis_tdata, output_axis_tkeep, output_axis_tlast, output_axis_tuser} = w_skid_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_in_acc) begin
      r_count <= input_axis_tlast ? '0 : w_len;
    end
  end

  // A frame ending while the held word is still unread loses the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status_valid   <= 1'b0;
      r_status_word    <= '0;
      r_status_dropped <= 1'b0;
    end else if (w_in_acc && input_axis_tlast) begin
      if (!r_status_valid || status_ready) begin
        r_status_valid <= 1'b1;
        r_status_word  <= {w_oversize, input_axis_tuser, w_len};
      end else begin
        r_status_dropped <= 1'b1;
      end
    end else if (r_status_valid && status_ready) begin
      r_status_valid <= 1'b0;
    end
  end

  assign status_valid     = r_status_valid;
  assign status_oversize  = r_status_word[c_STAT_W-1];
  assign status_error     = r_status_word[c_STAT_W-2];
  assign status_frame_len = r_status_word[LEN_WIDTH-1:0];
  assign status_dropped   = r_status_dropped;

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_len_8.sv
// ============================================================================
// Module   : tb_axis_frame_len_8
// Brief    : Self-checking bench for axis_frame_len_8 (frame model + directed).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_frame_len_8;

  localparam int c_MAX_LEN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_tdata = '0;
  logic        in_tkeep = 1'b0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic        in_tlast = 1'b0;
  logic        in_tuser = 1'b0;
  logic [7:0]  out_tdata;
  logic        out_tkeep;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic        out_tlast;
  logic        out_tuser;
  logic        st_valid;
  logic        st_ready = 1'b1;
  logic [15:0] st_len;
  logic        st_error;
  logic        st_oversize;
  logic        st_dropped;

  int checks = 0;
  int errors = 0;

  axis_frame_len_8 #(
    .MAX_LEN (c_MAX_LEN)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_tdata),
    .input_axis_tkeep   (in_tkeep),
    .input_axis_tvalid  (in_tvalid),
    .input_axis_tready  (in_tready),
    .input_axis_tlast   (in_tlast),
    .input_axis_tuser   (in_tuser),
    .output_axis_tdata  (out_tdata),
    .output_axis_tkeep  (out_tkeep),
    .output_axis_tvalid (out_tvalid),
    .output_axis_tready (out_tready),
    .output_axis_tlast  (out_tlast),
    .output_axis_tuser  (out_tuser),
    .status_valid       (st_valid),
    .status_ready       (st_ready),
    .status_frame_len   (st_len),
    .status_error       (st_error),
    .status_oversize    (st_oversize),
    .status_dropped     (st_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: expected output beats and the single status slot.
  logic [10:0] exp_q[$];
  int          m_cnt = 0;
  logic        m_sv = 1'b0;
  int          m_len = 0;
  logic        m_err = 1'b0;
  logic        m_ovs = 1'b0;
  logic        m_drop = 1'b0;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_beat = '0;
  logic        last_out_user = 1'b0;

  always @(negedge clk) begin
    logic [10:0] act;
    logic [10:0] exp;
    int          len;
    logic        ovs;
    act = {out_tdata, out_tkeep, out_tlast, out_tuser};
    if (rst) begin
      exp_q.delete();
      m_cnt = 0; m_sv = 1'b0; m_drop = 1'b0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold", {20'd0, out_tvalid, act}, {20'd0, 1'b1, prev_beat});
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", {21'd0, act}, 32'hffff_ffff);
        end else begin
          exp = exp_q.pop_front();
          chk("beat", {21'd0, act}, {21'd0, exp});
          if (out_tlast) last_out_user = out_tuser;
        end
      end
      prev_stall = out_tvalid && !out_tready;
      prev_beat  = act;

      chk("status_valid", {31'd0, st_valid}, {31'd0, m_sv});
      chk("status_dropped", {31'd0, st_dropped}, {31'd0, m_drop});
      if (m_sv) begin
        chk("status_len", {16'd0, st_len}, m_len);
        chk("status_error", {31'd0, st_error}, {31'd0, m_err});
        chk("status_oversize", {31'd0, st_oversize}, {31'd0, m_ovs});
      end

      if (in_tvalid && in_tready) begin
        len = m_cnt + int'(in_tkeep);
        if (len > 65535) len = 65535;
`ifdef AXIS_FRAME_LEN_MAXCHK_EN
        ovs = (len > c_MAX_LEN);
`else
        ovs = 1'b0;
`endif
        exp_q.push_back({in_tdata, in_tkeep, in_tlast, in_tuser | (in_tlast & ovs)});
        if (in_tlast) begin
          if (!m_sv || st_ready) begin
            m_sv = 1'b1; m_len = len; m_err = in_tuser; m_ovs = ovs;
          end else begin
            m_drop = 1'b1;
          end
          m_cnt = 0;
        end else begin
          m_cnt = len;
          if (m_sv && st_ready) m_sv = 1'b0;
        end
      end else if (m_sv && st_ready) begin
        m_sv = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic k, input logic l, input logic u);
    int   n;
    logic acc;
    n = 0;
    in_tvalid = 1'b1; in_tdata = d; in_tkeep = k; in_tlast = l; in_tuser = u;
    forever begin
      @(negedge clk);
      acc = in_tready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_tvalid = 1'b0; in_tlast = 1'b0; in_tuser = 1'b0;
  endtask

  task automatic send_seq(input int n, input logic [7:0] first, input logic u);
    for (int i = 0; i < n; i++)
      send_beat(first + 8'(i), 1'b1, (i == n - 1), (i == n - 1) ? u : 1'b0);
  endtask

  task automatic wait_status();
    int n;
    n = 0;
    @(negedge clk);
    while (!st_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!st_valid) chk("status_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] pat [5];
  logic       seen_drop;

  initial begin
    pat = '{8'hcd, 8'hab, 8'hcd, 8'hab, 8'hcd};

    repeat (2) @(negedge clk);
    chk("rst_tready", {31'd0, in_tready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_tvalid}, 32'd0);
    chk("rst_out_data", {24'd0, out_tdata}, 32'd0);
    chk("rst_status_valid", {31'd0, st_valid}, 32'd0);
    chk("rst_dropped", {31'd0, st_dropped}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Test 1: 5-byte frame at full rate, one cycle latency.
    for (int i = 0; i < 5; i++) begin
      send_beat(pat[i], 1'b1, (i == 4), 1'b0);
      if (i == 0) begin
        chk("t1_latency_valid", {31'd0, out_tvalid}, 32'd1);
        chk("t1_latency_data", {24'd0, out_tdata}, 32'hcd);
      end
    end
    wait_status();
    chk("t1_len", {16'd0, st_len}, 32'd5);
    chk("t1_error", {31'd0, st_error}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Test 2: output stalled three cycles mid-frame.
    seen_drop = 1'b0;
    fork
      for (int i = 0; i < 5; i++) send_beat(pat[i], 1'b1, (i == 4), 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1; out_tready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_tready) seen_drop = 1'b1;
        end
        @(posedge clk);
        #1; out_tready = 1'b1;
      end
    join
    chk("t2_tready_drop", {31'd0, seen_drop}, 32'd1);
    wait_status();
    chk("t2_len", {16'd0, st_len}, 32'd5);
    repeat (4) @(posedge clk);
    #1;

    // Test 3: 1-byte errored frame, then zero-byte frame.
    send_beat(8'h11, 1'b1, 1'b1, 1'b1);
    wait_status();
    chk("t3_len1", {16'd0, st_len}, 32'd1);
    chk("t3_err1", {31'd0, st_error}, 32'd1);
    @(posedge clk); #1;
    send_beat(8'h22, 1'b0, 1'b1, 1'b0);
    wait_status();
    chk("t3_len0", {16'd0, st_len}, 32'd0);
    chk("t3_err0", {31'd0, st_error}, 32'd0);
    @(posedge clk); #1;

    // Test 4: status held across two frames -> second word dropped.
    st_ready = 1'b0;
    send_seq(3, 8'h01, 1'b0);
    wait_status();
    chk("t4_len_first", {16'd0, st_len}, 32'd3);
    send_seq(3, 8'h41, 1'b1);
    repeat (2) @(negedge clk);
    chk("t4_len_held", {16'd0, st_len}, 32'd3);
    chk("t4_err_held", {31'd0, st_error}, 32'd0);
    chk("t4_dropped", {31'd0, st_dropped}, 32'd1);
    @(posedge clk); #1; st_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_popped", {31'd0, st_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Test 5: reset mid-frame, then a clean 4-byte frame.
    send_beat(8'h51, 1'b1, 1'b0, 1'b0);
    send_beat(8'h52, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", {31'd0, out_tvalid}, 32'd0);
    chk("t5_rst_tready", {31'd0, in_tready}, 32'd1);
    chk("t5_rst_status", {31'd0, st_valid}, 32'd0);
    chk("t5_rst_dropped", {31'd0, st_dropped}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    send_seq(4, 8'h61, 1'b0);
    wait_status();
    chk("t5_len", {16'd0, st_len}, 32'd4);
    chk("t5_dropped", {31'd0, st_dropped}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Test 6: 5-byte frame against MAX_LEN=4.
    send_seq(5, 8'h10, 1'b0);
    wait_status();
`ifdef AXIS_FRAME_LEN_MAXCHK_EN
    chk("t6_oversize", {31'd0, st_oversize}, 32'd1);
`else
    chk("t6_oversize", {31'd0, st_oversize}, 32'd0);
`endif
    chk("t6_len", {16'd0, st_len}, 32'd5);
    repeat (4) @(posedge clk);
    #1;
`ifdef AXIS_FRAME_LEN_MAXCHK_EN
    chk("t6_out_tuser", {31'd0, last_out_user}, 32'd1);
`else
    chk("t6_out_tuser", {31'd0, last_out_user}, 32'd0);
`endif
    chk("drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
